wb_bank_arbiter: RTL and testbench

WB_BANK_ARBITER -- requirements
Module: wb_bank_arbiter

---
 rtl/bus_map_pkg.sv | 29 ++
 rtl/bank_decode.sv | 25 ++
 rtl/wb_bank_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_bank_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_map_pkg.sv
// rtl/bus_map_pkg.sv - slave bus address map, bank encodings and arbiter FSM states
package bus_map_pkg;

  localparam int BANK_CNT = 5;

  // Exclusive upper bounds of each bank, kept 64-bit so any AW up to 64 compares unsigned.
  localparam logic [63:0] RAM_END  = 64'h0000_0000_2000_0000;
  localparam logic [63:0] CSR_END  = 64'h0000_0000_2800_0000;
  localparam logic [63:0] UART_END = 64'h0000_0000_3000_0000;
  localparam logic [63:0] GPIO_END = 64'h0000_0000_3800_0000;
  localparam logic [63:0] QSPI_END = 64'h0000_0000_4000_0000;

  localparam logic [BANK_CNT-1:0] BANK_NONE = 5'b00000;
  localparam logic [BANK_CNT-1:0] BANK_RAM  = 5'b00001;
  localparam logic [BANK_CNT-1:0] BANK_CSR  = 5'b00010;
  localparam logic [BANK_CNT-1:0] BANK_UART = 5'b00100;
  localparam logic [BANK_CNT-1:0] BANK_GPIO = 5'b01000;
  localparam logic [BANK_CNT-1:0] BANK_QSPI = 5'b10000;

  localparam logic [BANK_CNT-1:0] BANK_CACHABLE = BANK_RAM;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/bank_decode.sv
// rtl/bank_decode.sv - combinational address to one-hot bank and cachability decode
module bank_decode
  import bus_map_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0]       i_addr,
  output logic [BANK_CNT-1:0] o_bank,
  output logic                o_cachable
);

  logic [63:0] w_addr;

  always_comb begin
    w_addr = 64'(i_addr);
    if (w_addr < RAM_END)       o_bank = BANK_RAM;
    else if (w_addr < CSR_END)  o_bank = BANK_CSR;
    else if (w_addr < UART_END) o_bank = BANK_UART;
    else if (w_addr < GPIO_END) o_bank = BANK_GPIO;
    else if (w_addr < QSPI_END) o_bank = BANK_QSPI;
    else                        o_bank = BANK_NONE;
    o_cachable = |(o_bank & BANK_CACHABLE);
  end

endmodule

// File: rtl/wb_bank_arbiter.sv
// rtl/wb_bank_arbiter.sv - two-master round-robin arbiter onto a banked single-slave bus
module wb_bank_arbiter
  import bus_map_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [1:0]          i_m_cyc,
  input  logic [1:0]          i_m_stb,
  input  logic [1:0]          i_m_we,
  input  logic [2*AW-1:0]     i_m_addr,
  input  logic [2*DW-1:0]     i_m_data,
  input  logic [2*DW/8-1:0]   i_m_sel,
  output logic [1:0]          o_m_stall,
  output logic [1:0]          o_m_ack,
  output logic [1:0]          o_m_err,
  output logic [DW-1:0]       o_m_data,
  output logic                o_s_cyc,
  output logic                o_s_stb,
  output logic                o_s_we,
  output logic [AW-1:0]       o_s_addr,
  output logic [DW-1:0]       o_s_data,
  output logic [DW/8-1:0]     o_s_sel,
  output logic [BANK_CNT-1:0] o_s_bank,
  output logic                o_s_cachable,
  input  logic                i_s_ack,
  input  logic                i_s_err,
  input  logic                i_s_stall,
  input  logic [DW-1:0]       i_s_data
);

  localparam int SW = DW / 8;

  state_t              r_state, w_next;
  logic                r_gnt, r_last, r_we, r_cach, r_err;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_wdata, r_rdata;
  logic [SW-1:0]       r_sel;
  logic [BANK_CNT-1:0] r_bank;
  logic [7:0]          r_cnt;

  logic [1:0]          w_req;
  logic                w_grant, w_sel, w_cach, w_active, w_cyc_held, w_no_bank, w_resp, w_tmo;
  logic [AW-1:0]       w_addr;
  logic [BANK_CNT-1:0] w_bank;

  assign w_req   = i_m_cyc & i_m_stb;
  // Grant is suppressed while reset is held so the stalls read 2'b11 throughout reset.
  assign w_grant = (r_state == ST_IDLE) && (w_req != 2'b00) && !i_reset;
  assign w_sel   = (w_req == 2'b11) ? ~r_last : w_req[1];
  assign w_addr  = w_sel ? i_m_addr[2*AW-1:AW] : i_m_addr[AW-1:0];

  bank_decode #(.AW(AW)) u_bank_decode (
    .i_addr     (w_addr),
    .o_bank     (w_bank),
    .o_cachable (w_cach)
  );

  assign w_active   = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign w_cyc_held = i_m_cyc[r_gnt];
  assign w_no_bank  = (r_bank == BANK_NONE);
  assign w_resp     = ((r_state == ST_WAIT) || ((r_state == ST_REQ) && !i_s_stall))
                      && (i_s_ack || i_s_err);
  assign w_tmo      = (r_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_next = ST_REQ;
      ST_REQ, ST_WAIT: begin
        if (!w_cyc_held)                        w_next = ST_IDLE;
        else if (w_no_bank || w_resp || w_tmo)  w_next = ST_RESP;
        else if ((r_state == ST_REQ) && !i_s_stall) w_next = ST_WAIT;
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_m_stall = 2'b11;
    o_m_ack   = 2'b00;
    o_m_err   = 2'b00;
    o_s_cyc   = 1'b0;
    o_s_stb   = 1'b0;
    case (r_state)
      ST_IDLE: if (w_grant) o_m_stall[w_sel] = 1'b0;
      ST_REQ: begin
        o_s_cyc = !w_no_bank;
        o_s_stb = !w_no_bank;
      end
      ST_WAIT: o_s_cyc = !w_no_bank;
      ST_RESP: begin
        if (r_err) o_m_err[r_gnt] = 1'b1;
        else       o_m_ack[r_gnt] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_cach  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_sel   <= '0;
      r_bank  <= BANK_NONE;
      r_cnt   <= 8'd0;
    end else begin
      if (w_grant) begin
        r_gnt   <= w_sel;
        r_last  <= w_sel;
        r_addr  <= w_addr;
        r_wdata <= w_sel ? i_m_data[2*DW-1:DW] : i_m_data[DW-1:0];
        r_sel   <= w_sel ? i_m_sel[2*SW-1:SW] : i_m_sel[SW-1:0];
        r_we    <= w_sel ? i_m_we[1] : i_m_we[0];
        r_bank  <= w_bank;
        r_cach  <= w_cach;
        r_err   <= 1'b0;
      end
      if (w_active) begin
        r_cnt <= r_cnt + 8'd1;
        // A slave response on the final counted cycle beats the timeout.
        if (w_no_bank || (!w_resp && w_tmo)) begin
          r_err <= 1'b1;
        end else if (w_resp) begin
          r_err   <= i_s_err;
          r_rdata <= i_s_data;
        end
      end else begin
        r_cnt <= 8'd0;
      end
    end
  end

  assign o_s_we       = o_s_cyc & r_we;
  assign o_s_addr     = r_addr;
  assign o_s_data     = r_wdata;
  assign o_s_sel      = r_sel;
  assign o_s_bank     = r_bank;
  assign o_s_cachable = r_cach;
  assign o_m_data     = r_rdata;

endmodule

// File: tb/tb_wb_bank_arbiter.sv
// tb/tb_wb_bank_arbiter.sv - randomized self-checking bench for wb_bank_arbiter
module tb_wb_bank_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    m_cyc, m_stb, m_we;
  logic [63:0]   m_addr, m_data;
  logic [7:0]    m_sel;
  logic [1:0]    m_stall, m_ack, m_err;
  logic [31:0]   m_rdata;
  logic          s_cyc, s_stb, s_we, s_cach;
  logic [31:0]   s_addr, s_wdata, s_rdata;
  logic [3:0]    s_sel;
  logic [4:0]    s_bank;
  logic          s_ack, s_err, s_stall;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_last;

  always #5 clk = ~clk;

  wb_bank_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_m_cyc      (m_cyc),
    .i_m_stb      (m_stb),
    .i_m_we       (m_we),
    .i_m_addr     (m_addr),
    .i_m_data     (m_data),
    .i_m_sel      (m_sel),
    .o_m_stall    (m_stall),
    .o_m_ack      (m_ack),
    .o_m_err      (m_err),
    .o_m_data     (m_rdata),
    .o_s_cyc      (s_cyc),
    .o_s_stb      (s_stb),
    .o_s_we       (s_we),
    .o_s_addr     (s_addr),
    .o_s_data     (s_wdata),
    .o_s_sel      (s_sel),
    .o_s_bank     (s_bank),
    .o_s_cachable (s_cach),
    .i_s_ack      (s_ack),
    .i_s_err      (s_err),
    .i_s_stall    (s_stall),
    .i_s_data     (s_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // The map is carved in 128 MB regions: four for RAM, then one each for the other banks.
  function automatic logic [4:0] ref_bank(input logic [31:0] a);
    logic [4:0] b;
    case (a >> 27)
      0, 1, 2, 3: b = 5'b00001;
      4:          b = 5'b00010;
      5:          b = 5'b00100;
      6:          b = 5'b01000;
      7:          b = 5'b10000;
      default:    b = 5'b00000;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] edges [5];
    logic [31:0] a;
    edges[0] = 32'h2000_0000; edges[1] = 32'h2800_0000; edges[2] = 32'h3000_0000;
    edges[3] = 32'h3800_0000; edges[4] = 32'h4000_0000;
    if ($urandom_range(0, 1) == 0) begin
      a = edges[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 0) a = a - 32'd4;
    end else begin
      a = $urandom & 32'h7FFF_FFFC;
    end
    return a;
  endfunction

  // mode: 0 slave acks, 1 slave errs, 2 slave silent. abort_at>0 drops the winner's cyc in that cycle.
  task automatic run_txn(input string name, input logic [1:0] mask, input logic [31:0] a0,
                         input logic [31:0] a1, input logic we, input int s, input int d,
                         input int mode, input int abort_at);
    int win, n, exp_t, exp_stb, exp_cyc, t_end;
    int stb_cnt, cyc_cnt, hit_cnt, hit_t, stray, busy_bad;
    logic [1:0] wmask, stall_exp;
    logic [4:0] bank;
    logic valid, exp_err, got_err, resp;
    logic [31:0] a, dat, got_data, rsp_data, exp_wdata;
    logic [3:0] sel, exp_sel;

    win   = (mask == 2'b11) ? (exp_last ? 0 : 1) : ((mask == 2'b10) ? 1 : 0);
    wmask = (win == 1) ? 2'b10 : 2'b01;
    a     = (win == 1) ? a1 : a0;
    bank  = ref_bank(a);
    valid = (bank != 5'b0);
    n     = (mode == 2) ? 1000 : s + 1 + d;
    if (!valid) begin
      exp_t = 2; exp_err = 1'b1;
    end else if (n > TO) begin
      exp_t = TO + 1; exp_err = 1'b1;
    end else begin
      exp_t = n + 1; exp_err = (mode == 1);
    end
    exp_stb = valid ? ((s + 1 < TO) ? s + 1 : TO) : 0;
    exp_cyc = valid ? ((n < TO) ? n : TO) : 0;
    if (abort_at > 0) begin
      exp_stb = valid ? ((s + 1 < abort_at) ? s + 1 : abort_at) : 0;
      exp_cyc = valid ? abort_at : 0;
    end
    stb_cnt = 0; cyc_cnt = 0; hit_cnt = 0; hit_t = 0; stray = 0; busy_bad = 0;
    got_err = 1'b0; got_data = '0; rsp_data = '0;

    @(negedge clk);
    dat = $urandom;
    sel = 4'($urandom);
    exp_wdata = (win == 1) ? dat : ~dat;
    exp_sel   = (win == 1) ? sel : ~sel;
    m_cyc  = mask;
    m_stb  = mask;
    m_we   = {we, we};
    m_addr = {a1, a0};
    m_data = {dat, ~dat};
    m_sel  = {sel, ~sel};
    #1;
    stall_exp = ~wmask;
    check_eq({name, ":grant_stall"}, 64'(m_stall), 64'(stall_exp));
    exp_last = (win == 1);
    @(posedge clk);

    t_end = (abort_at > 0) ? abort_at + 3 : exp_t + 1;
    for (int t = 1; t <= t_end; t++) begin
      @(negedge clk);
      if (s_stb) stb_cnt++;
      if (s_cyc) cyc_cnt++;
      if (m_stall != 2'b11) busy_bad++;
      if ((m_ack & wmask) != 2'b0 || (m_err & wmask) != 2'b0) begin
        hit_cnt++;
        hit_t    = t;
        got_err  = ((m_err & wmask) != 2'b0);
        got_data = m_rdata;
      end
      if ((m_ack & ~wmask) != 2'b0 || (m_err & ~wmask) != 2'b0) stray++;
      if (t == 1 && valid) begin
        check_eq({name, ":bank"}, 64'(s_bank), 64'(bank));
        check_eq({name, ":cachable"}, 64'(s_cach), 64'(bank == 5'b00001));
        check_eq({name, ":addr"}, 64'(s_addr), 64'(a));
        check_eq({name, ":we"}, 64'(s_we), 64'(we));
        check_eq({name, ":wdata"}, 64'(s_wdata), 64'(exp_wdata));
        check_eq({name, ":sel"}, 64'(s_sel), 64'(exp_sel));
      end
      m_stb = 2'b00;
      m_cyc = (abort_at > 0 && t >= abort_at) ? 2'b00 : wmask;
      s_stall = (t <= s);
      s_rdata = $urandom;
      resp    = (mode != 2) && (t == s + 1 + d);
      s_ack   = resp && (mode == 0);
      s_err   = resp && (mode == 1);
      if (resp) rsp_data = s_rdata;
    end

    s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
    m_cyc = 2'b00; m_stb = 2'b00;
    check_eq({name, ":stb_cycles"}, 64'(stb_cnt), 64'(exp_stb));
    check_eq({name, ":cyc_cycles"}, 64'(cyc_cnt), 64'(exp_cyc));
    check_eq({name, ":stray_resp"}, 64'(stray), 64'd0);
    check_eq({name, ":stall_busy"}, 64'(busy_bad), 64'd0);
    if (abort_at > 0) begin
      check_eq({name, ":abort_resp"}, 64'(hit_cnt), 64'd0);
    end else begin
      check_eq({name, ":resp_count"}, 64'(hit_cnt), 64'd1);
      check_eq({name, ":resp_cycle"}, 64'(hit_t), 64'(exp_t));
      check_eq({name, ":resp_err"}, 64'(got_err), 64'(exp_err));
      if (!exp_err) check_eq({name, ":rdata"}, 64'(got_data), 64'(rsp_data));
    end
  endtask

  task automatic check_cleared(input string name);
    check_eq({name, ":stall"}, 64'(m_stall), 64'h3);
    check_eq({name, ":ack_err"}, 64'({m_ack, m_err}), 64'd0);
    check_eq({name, ":s_ctl"}, 64'({s_cyc, s_stb, s_we, s_cach}), 64'd0);
    check_eq({name, ":s_bank"}, 64'(s_bank), 64'd0);
    check_eq({name, ":s_bus"}, {s_addr, s_wdata}, 64'd0);
    check_eq({name, ":m_data"}, 64'(m_rdata), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [1:0] mask;
    int r, md;

    rst = 1'b1;
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
    m_addr = '0; m_data = '0; m_sel = '0;
    s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_rdata = '0;
    exp_last = 1'b1;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    m_cyc = 2'b00; m_stb = 2'b00;
    rst = 1'b0;

    for (int i = 0; i < 3; i++)
      run_txn("tie", 2'b11, 32'h0000_0100, 32'h2000_0200, 1'b0, 0, 1, 0, 0);

    run_txn("m0_ram_read", 2'b01, 32'h0000_0010, 32'h0, 1'b0, 0, 1, 0, 0);
    run_txn("m1_stall_write", 2'b10, 32'h0, 32'h3000_0004, 1'b1, 3, 0, 0, 0);
    run_txn("m1_nobank", 2'b10, 32'h0, 32'h4000_0000, 1'b0, 0, 0, 0, 0);
    run_txn("m1_qspi_top", 2'b10, 32'h0, 32'h3FFF_FFFC, 1'b0, 0, 0, 0, 0);
    run_txn("slave_err", 2'b01, 32'h2000_0000, 32'h0, 1'b0, 1, 1, 1, 0);
    run_txn("timeout", 2'b01, 32'h0000_1000, 32'h0, 1'b0, 0, 0, 2, 0);
    run_txn("abort", 2'b10, 32'h0, 32'h2000_0010, 1'b0, 10, 0, 2, 2);

    for (int i = 0; i < 40; i++) begin
      mask = 2'($urandom_range(1, 3));
      r    = $urandom_range(0, 9);
      md   = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      run_txn("rand", mask, pick_addr(), pick_addr(), 1'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), md, 0);
    end

    // Reset while the slave cycle sits in its wait phase.
    @(negedge clk);
    m_cyc = 2'b01; m_stb = 2'b01; m_addr = {32'h0, 32'h0000_0100}; m_we = 2'b00;
    @(negedge clk);
    m_stb = 2'b00;
    @(negedge clk);
    check_eq("wait_phase:s_cyc", 64'({s_cyc, s_stb}), 64'h2);
    #1 rst = 1'b1;
    #1 check_cleared("reset_in_wait");
    @(negedge clk);
    rst = 1'b0;
    m_cyc = 2'b00;
    exp_last = 1'b1;
    run_txn("post_reset_tie", 2'b11, 32'h0000_0040, 32'h0000_0080, 1'b0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
